// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared FSM state type and register-map constants for the SPI register slave.
package spi_regs_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    localparam logic [6:0] ADDR_ID   = 7'd0;
    localparam logic [6:0] ADDR_CTRL = 7'd1;
    function automatic int gpio_out_base();
        return int'(ADDR_CTRL) + 1;
    endfunction
    function automatic int gpio_in_base(int g);
        return gpio_out_base() + g;
    endfunction
endpackage

// File: rtl/spi_regs_slave_if.sv
// spi_regs_slave_if: four-wire SPI bus between a master and the register slave.
interface spi_regs_slave_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;
    modport master(output ss, sclk, mosi, input miso);
    modport slave(input ss, sclk, mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sr;
    logic q_d;
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sr  <= '0;
            q_d <= 1'b0;
        end else begin
            sr  <= {sr[STAGES-2:0], d};
            q_d <= q;
        end
    end
    assign q    = sr[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/spi_regs_slave.sv
// spi_regs_slave: SPI slave (modes 0-3) exposing ID, CTRL and little-endian GPIO byte registers.
module spi_regs_slave
    import spi_regs_pkg::*;
#(
    parameter int         N_GPIO      = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VAL      = 8'hA5
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    spi_regs_slave_if.slave   spi,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic              busy,
    output logic              wr_pulse
);
    localparam int         G        = N_GPIO / 8;
    localparam logic [6:0] OUT_BASE = 7'(gpio_out_base());
    localparam logic [6:0] IN_BASE  = 7'(gpio_in_base(G));
    localparam logic [6:0] LAST     = 7'(gpio_in_base(G) + G - 1);

    state_t state, state_nxt;
    logic ss_q, ss_rise, ss_fall, sclk_q, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [SYNC_STAGES:0] settle;
    logic armed, wr, skip, soft_rst;
    logic [1:0] ctrl, mode;
    logic [2:0] bit_cnt;
    logic [6:0] addr, addr_nxt, ld_addr;
    logic [7:0] rx, rx_byte, tx, rd_byte;
    logic start, active, sclk_edge, lead, trail, samp, shft, byte_done, do_load, do_wr, wr_ok;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .sys_clk(sys_clk), .rst_n(rst_n), .d(spi.ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .sys_clk(sys_clk), .rst_n(rst_n), .d(spi.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign busy      = ss_q;
    assign spi.miso  = ss_q & ~wr & tx[7];
    assign start     = state == IDLE && ss_rise && armed;
    assign active    = ss_q && state != IDLE;
    // A leading edge moves sclk away from its CPOL idle level
    assign sclk_edge = sclk_rise | sclk_fall;
    assign lead      = sclk_edge & (sclk_q ^ mode[1]);
    assign trail     = sclk_edge & ~(sclk_q ^ mode[1]);
    assign samp      = active & (mode[0] ? trail : lead);
    assign shft      = active & (mode[0] ? lead : trail);
    assign rx_byte   = {rx[6:0], mosi_sr[SYNC_STAGES-1]};
    assign byte_done = samp && bit_cnt == 3'd7;
    assign addr_nxt  = addr >= LAST ? 7'd0 : addr + 7'd1;
    assign ld_addr   = state == CMD ? rx_byte[6:0] : addr_nxt;
    assign do_load   = byte_done && (state == CMD ? !rx_byte[7] : !wr);
    assign do_wr     = byte_done && state == DATA && wr;
    assign wr_ok     = addr == ADDR_CTRL || (addr >= OUT_BASE && addr < IN_BASE);

    always_comb begin
        rd_byte = ld_addr == ADDR_ID ? ID_VAL : ld_addr == ADDR_CTRL ? {6'd0, ctrl} : 8'h00;
        for (int i = 0; i < G; i++) begin
            if (ld_addr == OUT_BASE + 7'(i)) rd_byte = gpio_out[8*i +: 8];
            if (ld_addr == IN_BASE + 7'(i)) rd_byte = gpio_in[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = ss_fall ? IDLE : start ? CMD : (state == CMD && byte_done) ? DATA : state;
    end

    always_ff @(posedge sys_clk) begin
        state <= !rst_n ? IDLE : state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            mosi_sr  <= '0;
            settle   <= '0;
            armed    <= 1'b0;
            mode     <= 2'd0;
            ctrl     <= 2'd0;
            gpio_out <= '0;
            wr_pulse <= 1'b0;
            soft_rst <= 1'b0;
            bit_cnt  <= 3'd0;
            addr     <= 7'd0;
            rx       <= 8'h00;
            tx       <= 8'h00;
            skip     <= 1'b0;
            wr       <= 1'b0;
        end else begin
            mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi.mosi};
            // A frame is accepted only after a genuine low level of ss has been observed
            settle   <= {settle[SYNC_STAGES-1:0], 1'b1};
            armed    <= armed | (settle[SYNC_STAGES] & ~ss_q);
            wr_pulse <= do_wr & wr_ok;
            soft_rst <= do_wr && addr == ADDR_CTRL && rx_byte[7];
            if (start) begin
                mode    <= ctrl;
                bit_cnt <= 3'd0;
                rx      <= 8'h00;
                tx      <= 8'h00;
                skip    <= 1'b0;
                wr      <= 1'b0;
            end
            if (samp) begin
                rx      <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done && state == CMD) begin
                wr   <= rx_byte[7];
                addr <= rx_byte[6:0];
            end
            if (byte_done && state == DATA) addr <= addr_nxt;
            // The first shift edge after a load presents bit 7 rather than shifting past it
            if (do_load) begin
                tx   <= rd_byte;
                skip <= 1'b1;
            end else if (shft) begin
                tx   <= skip ? tx : {tx[6:0], 1'b0};
                skip <= 1'b0;
            end
            if (do_wr && addr == ADDR_CTRL) ctrl <= rx_byte[1:0];
            for (int i = 0; i < G; i++)
                if (do_wr && addr == OUT_BASE + 7'(i)) gpio_out[8*i +: 8] <= rx_byte;
            if (soft_rst) begin
                ctrl     <= 2'd0;
                gpio_out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_regs_slave.sv
// tb_spi_regs_slave: directed vector bench driving a 16-bit and an 8-bit GPIO slave from one SPI master.
module tb_spi_regs_slave;
    localparam int HALF = 80;

    typedef struct {
        string       name;
        int          nbits;
        logic [1:0]  md;
        logic        sel8;
        logic [31:0] d;
        logic [31:0] r;
        logic [15:0] g16;
        logic [7:0]  g8;
        int          p16;
        int          p8;
    } vec_t;

    logic sys_clk = 1'b0, rst_n = 1'b0, ss = 1'b0, sclk = 1'b0, mosi = 1'b0, sel8 = 1'b0;
    logic [15:0] gin16 = 16'h1234, gout16;
    logic [7:0]  gin8 = 8'h5C, gout8;
    logic busy16, busy8, wrp16, wrp8, miso_sel, d16 = 1'b0, d8 = 1'b0;
    int wp16 = 0, hi16 = 0, wp8 = 0, hi8 = 0, passed = 0, total = 0;
    vec_t vecs[12];

    spi_regs_slave_if if16();
    spi_regs_slave_if if8();
    assign if16.ss = ss;
    assign if16.sclk = sclk;
    assign if16.mosi = mosi;
    assign if8.ss = ss;
    assign if8.sclk = sclk;
    assign if8.mosi = mosi;
    assign miso_sel = sel8 ? if8.miso : if16.miso;

    spi_regs_slave #(.N_GPIO(16)) dut16 (
        .sys_clk(sys_clk), .rst_n(rst_n), .spi(if16.slave), .gpio_in(gin16),
        .gpio_out(gout16), .busy(busy16), .wr_pulse(wrp16)
    );
    spi_regs_slave #(.N_GPIO(8)) dut8 (
        .sys_clk(sys_clk), .rst_n(rst_n), .spi(if8.slave), .gpio_in(gin8),
        .gpio_out(gout8), .busy(busy8), .wr_pulse(wrp8)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (wrp16 && !d16) wp16++;
        if (wrp16) hi16++;
        if (wrp8 && !d8) wp8++;
        if (wrp8) hi8++;
        d16 = wrp16;
        d8 = wrp8;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic clk_byte(input logic [7:0] d, input int n, input logic [1:0] md, output logic [7:0] r);
        r = 8'h00;
        for (int b = 0; b < n; b++) begin
            if (!md[0]) begin
                mosi = d[7-b];
                #HALF;
                r[7-b] = miso_sel;
                sclk = ~md[1];
                #HALF;
                sclk = md[1];
            end else begin
                sclk = ~md[1];
                mosi = d[7-b];
                #HALF;
                r[7-b] = miso_sel;
                sclk = md[1];
                #HALF;
            end
        end
    endtask

    task automatic xfer(input int nbits, input logic [1:0] md, input logic [31:0] d, output logic [31:0] r);
        logic [7:0] rb;
        r = '0;
        sclk = md[1];
        #(2*HALF);
        ss = 1'b1;
        #(2*HALF);
        for (int i = 0; i < 4; i++)
            if (nbits - 8*i > 0) begin
                clk_byte(d[31-8*i -: 8], (nbits - 8*i > 8) ? 8 : nbits - 8*i, md, rb);
                r[31-8*i -: 8] = rb;
            end
        #HALF;
        ss = 1'b0;
        #(4*HALF);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0] rb;
        int b16, b8, h16, h8;
        vecs[0]  = '{"wr_gpio",    24, 2'd0, 1'b0, 32'h82AA5500, 32'h00000000, 16'h55AA, 8'hAA, 2, 1};
        vecs[1]  = '{"rd_id",      24, 2'd0, 1'b0, 32'h00000000, 32'h00A50000, 16'h55AA, 8'hAA, 0, 0};
        vecs[2]  = '{"wr_ctrl3",   16, 2'd0, 1'b0, 32'h81030000, 32'h00000000, 16'h55AA, 8'hAA, 1, 1};
        vecs[3]  = '{"rd_in16_m3", 24, 2'd3, 1'b0, 32'h04000000, 32'h00341200, 16'h55AA, 8'hAA, 0, 0};
        vecs[4]  = '{"rd8_wrap",   32, 2'd3, 1'b1, 32'h03000000, 32'h005CA503, 16'h55AA, 8'hAA, 0, 0};
        vecs[5]  = '{"abort_wr",   13, 2'd3, 1'b0, 32'h820F0000, 32'h00000000, 16'h55AA, 8'hAA, 0, 0};
        vecs[6]  = '{"wr8_wrap",   32, 2'd3, 1'b1, 32'h83112243, 32'h00000000, 16'h11AA, 8'hAA, 1, 1};
        vecs[7]  = '{"rd_ctrl",    16, 2'd3, 1'b1, 32'h01000000, 32'h00030000, 16'h11AA, 8'hAA, 0, 0};
        vecs[8]  = '{"wr_ff",      16, 2'd3, 1'b1, 32'h82FF0000, 32'h00000000, 16'h11FF, 8'hFF, 1, 1};
        vecs[9]  = '{"soft_rst",   16, 2'd3, 1'b1, 32'h81800000, 32'h00000000, 16'h0000, 8'h00, 1, 1};
        vecs[10] = '{"rd_mode0",   16, 2'd0, 1'b1, 32'h00000000, 32'h00A50000, 16'h0000, 8'h00, 0, 0};
        vecs[11] = '{"wr_5a",      16, 2'd0, 1'b1, 32'h825A0000, 32'h00000000, 16'h005A, 8'h5A, 1, 1};

        repeat (4) @(negedge sys_clk);
        chk("rst_gpio16", 32'(gout16), 0);
        chk("rst_gpio8", 32'(gout8), 0);
        chk("rst_busy", {busy16, busy8}, 0);
        chk("rst_miso", {if16.miso, if8.miso}, 0);
        chk("rst_wr_pulse", {wrp16, wrp8}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        for (int v = 0; v < 12; v++) begin
            sel8 = vecs[v].sel8;
            b16 = wp16; b8 = wp8; h16 = hi16; h8 = hi8;
            xfer(vecs[v].nbits, vecs[v].md, vecs[v].d, r);
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s_miso%0d", vecs[v].name, i), 32'(r[31-8*i -: 8]), 32'(vecs[v].r[31-8*i -: 8]));
            chk({vecs[v].name, "_gpio16"}, 32'(gout16), 32'(vecs[v].g16));
            chk({vecs[v].name, "_gpio8"}, 32'(gout8), 32'(vecs[v].g8));
            chk({vecs[v].name, "_pulses16"}, wp16 - b16, vecs[v].p16);
            chk({vecs[v].name, "_pulses8"}, wp8 - b8, vecs[v].p8);
            chk({vecs[v].name, "_pulse_cyc16"}, hi16 - h16, vecs[v].p16);
            chk({vecs[v].name, "_pulse_cyc8"}, hi8 - h8, vecs[v].p8);
        end

        // Reset in the middle of a write frame, then a frame with ss still high after reset
        sel8 = 1'b1;
        sclk = 1'b0;
        #(2*HALF);
        ss = 1'b1;
        #(2*HALF);
        chk("busy_in_frame", {busy16, busy8}, 2'b11);
        clk_byte(8'h82, 8, 2'd0, rb);
        clk_byte(8'hC3, 4, 2'd0, rb);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("midrst_gpio16", 32'(gout16), 0);
        chk("midrst_gpio8", 32'(gout8), 0);
        chk("midrst_busy", {busy16, busy8}, 0);
        chk("midrst_miso", {if16.miso, if8.miso}, 0);
        chk("midrst_wr_pulse", {wrp16, wrp8}, 0);
        rst_n = 1'b1;
        b16 = wp16; b8 = wp8;
        #(4*HALF);
        clk_byte(8'h82, 8, 2'd0, rb);
        clk_byte(8'h77, 8, 2'd0, rb);
        #HALF;
        chk("stale_ss_gpio8", 32'(gout8), 0);
        chk("stale_ss_gpio16", 32'(gout16), 0);
        chk("stale_ss_pulses", wp16 + wp8 - b16 - b8, 0);
        ss = 1'b0;
        #(4*HALF);
        xfer(16, 2'd0, 32'h82770000, r);
        chk("post_rst_gpio8", 32'(gout8), 32'h77);
        chk("post_rst_gpio16", 32'(gout16), 32'h0077);
        chk("post_rst_pulses", wp16 + wp8 - b16 - b8, 2);
        xfer(16, 2'd0, 32'h00000000, r);
        chk("post_rst_rd_id", r, 32'h00A50000);
        chk("pulse_width16", hi16, wp16);
        chk("pulse_width8", hi8, wp8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_regs_slave.md
SPI_REGS_SLAVE -- requirements
Module: spi_regs_slave

Interface
REQ-001 Parameters SHALL be:
- N_GPIO, 8, GPIO width; SHALL be 8, 16, 24 or 32.
- SYNC_STAGES, 2, synchroniser depth on ss/sclk/mosi; SHALL be at least 2.
- ID_VAL, 8'hA5, value returned by register 0.

REQ-002 Ports SHALL be:
- sys_clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- ss  in  1  slave select, active-high, asynchronous to sys_clk.
- sclk  in  1  SPI clock, asynchronous; frequency at most sys_clk/8.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- gpio_in  in  N_GPIO  inputs, sampled for readback.
- gpio_out  out  N_GPIO  output register.
- busy  out  1  synchronised ss.
- wr_pulse  out  1  one-cycle strobe per committed register write.

Function
REQ-003 ss, sclk and mosi SHALL each pass through SYNC_STAGES flops; sclk edges SHALL be detected on the synchronised signal.
REQ-004 Mode SHALL come from CTRL[1:0] = {CPOL, CPHA}: sample on the leading edge and shift on the trailing edge when CPHA=0; shift on the leading edge and sample on the trailing edge when CPHA=1.
REQ-005 A mode change SHALL take effect only on the next rising edge of synchronised ss.
REQ-006 The FSM SHALL have the states IDLE, CMD, DATA. Transitions:
- IDLE->CMD on ss rise.
- CMD->DATA after 8 sampled bits.
- Any state->IDLE on ss fall.
REQ-007 The command byte SHALL be bit7 = W/nR and bits[6:0] = start address.
REQ-008 In DATA state, every 8 sampled bits SHALL complete one data byte, and the address SHALL then auto-increment.
REQ-009 When the incremented address passes the last valid address, it SHALL wrap to 0.
REQ-010 The register map SHALL be:
- 0: ID, read-only.
- 1: CTRL, bits[1:0] mode, bit7 soft-reset; write-only bit that reads as 0.
- 2..2+G-1: gpio_out bytes, little-endian, G = N_GPIO/8.
- 2+G..2+2G-1: gpio_in bytes, read-only.
REQ-011 A write SHALL commit within 2 sys_clk cycles after the 8th data bit is sampled.
REQ-012 On each write commit, wr_pulse SHALL assert for exactly one cycle.
REQ-013 Writes to read-only or out-of-range addresses SHALL be discarded without asserting wr_pulse.
REQ-014 Reads from out-of-range addresses SHALL return 8'h00.
REQ-015 Read data for the current address SHALL be loaded into the shift register before the first shift edge of that byte.
- gpio_in SHALL be captured at load time.
- With CPHA=0, the first bit SHALL appear on miso within 2 cycles of the 8th command bit.
REQ-016 miso SHALL be 0 whenever busy=0 and whenever a write frame is in progress.
REQ-017 An ss fall mid-byte SHALL discard the partial byte, and no write SHALL commit.
REQ-018 An ss rise in the same cycle as a pending write commit SHALL still commit that write.
REQ-019 Writing CTRL bit7=1 SHALL reset gpio_out and CTRL to reset values one cycle after the commit.
- The soft reset SHALL leave the FSM in progress; the current frame continues.
REQ-020 Bits sampled after an address wrap SHALL follow REQ-010 through REQ-014 for the wrapped address.

Reset
REQ-021 When rst_n=0 at a sys_clk edge, the block SHALL reset to:
- FSM in IDLE, CTRL = 0 (mode 0).
- gpio_out = 0, miso = 0, wr_pulse = 0, busy = 0.
- Synchroniser flops = 0.
- Bit and address counters = 0.
REQ-022 A reset asserted mid-frame SHALL abort the frame with no commit.
REQ-023 After reset, the block SHALL ignore the frame until ss is seen low, then high again.

Structure
REQ-024 A shared package spi_regs_pkg SHALL hold:
- The FSM state typedef.
- Address constants ADDR_ID and ADDR_CTRL.
- Function-style constants for GPIO_OUT_BASE and GPIO_IN_BASE, derived from G.
REQ-025 One sub-module, spi_sync_edge, SHALL contain the per-signal synchroniser and rise/fall detector.
- It SHALL be instantiated for ss and sclk.
- mosi SHALL use the synchroniser output only.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Mode 0, N_GPIO=16: write cmd 8'h82, then data 8'hAA, 8'h55 -> gpio_out=16'h55AA; wr_pulse pulses twice.
- Read cmd 8'h00 -> miso returns 8'hA5; then auto-incremented CTRL reads 8'h00.
- Write CTRL=8'h03; new frame in mode 3, read gpio_in=16'h1234 from addr 4 -> bytes 8'h34, 8'h12.
- ss dropped after 5 data bits of a write to addr 2 -> gpio_out unchanged; no wr_pulse.
- N_GPIO=8: write from addr 3 with 3 bytes -> addr 3 ignored; wrap to addr 0 ignored; addr 1 gets the 3rd byte.
- Write CTRL=8'h80 after gpio_out=8'hFF -> gpio_out=0 and mode 0; rst_n low mid-frame -> every REQ-021 value restored.
